// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: sequential front-end for a 32-bit combinational ALU.
//
// Commands arrive on a valid/ready channel and are queued in a small FIFO. One
// command at a time is issued on registered ALU operand/control lines; after Settle
// cycles the ALU result and flags are captured and returned as a tagged response on
// a valid/ready channel. Illegal control codes bypass the ALU and answer with rsp_err_o.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o command handshake (ready = FIFO not full)
//   cmd_src1_i, cmd_src2_i    operands A/B
//   cmd_ctrl_i, cmd_tag_i     ALU control code, opaque tag
//   alu_rst_no                registered copy of rst_ni for the ALU
//   alu_src1_o, alu_src2_o    registered ALU operands
//   alu_ctrl_o                registered ALU control
//   alu_result_i, alu_*_i     ALU result and zero/cout/overflow flags
//   rsp_valid_o / rsp_ready_i response handshake
//   rsp_result_o, rsp_flags_o captured result, {overflow, cout, zero}
//   rsp_err_o, rsp_tag_o      illegal-code indication, echoed tag
//   busy_o                    FSM active or FIFO non-empty
//   op_count_o                number of completed response handshakes (wraps)
module alu_cmd_driver #(
    parameter int unsigned Settle    = 1,  // 1..15
    parameter int unsigned FifoDepth = 4   // power of 2, >= 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_src1_i,
    input  logic [31:0] cmd_src2_i,
    input  logic [3:0]  cmd_ctrl_i,
    input  logic [3:0]  cmd_tag_i,
    output logic        alu_rst_no,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    input  logic        alu_cout_i,
    input  logic        alu_overflow_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic [2:0]  rsp_flags_o,
    output logic        rsp_err_o,
    output logic [3:0]  rsp_tag_o,
    output logic        busy_o,
    output logic [15:0] op_count_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [3:0]  SettleInit = 4'(Settle - 1);

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  ctrl;
        logic [3:0]  tag;
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    // ---------------------------------------------------------------- FIFO
    cmd_t            mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop, fifo_empty;
    cmd_t            head;

    // Gated by rst_ni so nothing is accepted while reset is held.
    assign cmd_ready_o = rst_ni && (count_q != CntW'(FifoDepth));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign fifo_empty  = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{src1: cmd_src1_i, src2: cmd_src2_i,
                                 ctrl: cmd_ctrl_i, tag: cmd_tag_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-2 depth: pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    function automatic logic ctrl_legal(input logic [3:0] ctrl);
        case (ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    // ---------------------------------------------------------------- FSM
    state_e      state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [31:0] alu_src1_q, alu_src1_d, alu_src2_q, alu_src2_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [2:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  rsp_tag_q, rsp_tag_d;
    logic [15:0] op_count_q, op_count_d;
    logic        alu_rst_n_q;

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        alu_src1_d   = alu_src1_q;
        alu_src2_d   = alu_src2_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;
        op_count_d   = op_count_q;
        pop          = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    rsp_tag_d = head.tag;
                    if (ctrl_legal(head.ctrl)) begin
                        alu_src1_d = head.src1;
                        alu_src2_d = head.src2;
                        alu_ctrl_d = head.ctrl;
                        settle_d   = SettleInit;
                        state_d    = StSettle;
                    end else begin
                        // ALU is left untouched; answer immediately.
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = StResp;
                    end
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    rsp_result_d = alu_result_i;
                    rsp_flags_d  = {alu_overflow_i, alu_cout_i, alu_zero_i};
                    rsp_err_d    = 1'b0;
                    state_d      = StResp;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            settle_q     <= '0;
            alu_src1_q   <= '0;
            alu_src2_q   <= '0;
            alu_ctrl_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            alu_src1_q   <= alu_src1_d;
            alu_src2_q   <= alu_src2_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
            op_count_q   <= op_count_d;
        end
    end

    // One-cycle delayed copy of the reset for the ALU.
    always_ff @(posedge clk_i) begin
        alu_rst_n_q <= rst_ni;
    end

    assign alu_rst_no   = alu_rst_n_q;
    assign alu_src1_o   = alu_src1_q;
    assign alu_src2_o   = alu_src2_q;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign rsp_valid_o  = (state_q == StResp);
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign busy_o       = (state_q != StIdle) || !fifo_empty;
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: instance a uses Settle=1, instance b uses Settle=3.
// Expected responses are queued when a command is issued; per-instance monitors
// pop and compare on each response handshake.
module tb_alu_cmd_driver;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flags;
        logic        err;
        logic [3:0]  tag;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd_src1 = '0, cmd_src2 = '0;
    logic [3:0]  cmd_ctrl = '0, cmd_tag = '0;

    logic        cmd_valid_a = 1'b0, cmd_ready_a, alu_rst_n_a, rsp_valid_a, rsp_ready_a = 1'b1;
    logic [31:0] alu_src1_a, alu_src2_a, alu_result_a, rsp_result_a;
    logic [3:0]  alu_ctrl_a, rsp_tag_a;
    logic        alu_zero_a, alu_cout_a, alu_overflow_a, rsp_err_a, busy_a;
    logic [2:0]  rsp_flags_a;
    logic [15:0] op_count_a;

    logic        cmd_valid_b = 1'b0, cmd_ready_b, alu_rst_n_b, rsp_valid_b, rsp_ready_b = 1'b1;
    logic [31:0] alu_src1_b, alu_src2_b, alu_result_b, rsp_result_b;
    logic [3:0]  alu_ctrl_b, rsp_tag_b;
    logic        alu_zero_b, alu_cout_b, alu_overflow_b, rsp_err_b, busy_b;
    logic [2:0]  rsp_flags_b;
    logic [15:0] op_count_b;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    // Stand-in for the combinational ALU; returns {result, overflow, cout, zero}.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        co, ov;
        co = 1'b0;
        ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
                if (c == 4'b0111) r = {31'b0, r[31] ^ ov};
            end
            4'b1100: r = ~(a | b);
            default: r = 32'hDEAD_BEEF;
        endcase
        return {r, ov, co, (r == 32'd0)};
    endfunction

    assign {alu_result_a, alu_overflow_a, alu_cout_a, alu_zero_a} =
        alu_model(alu_src1_a, alu_src2_a, alu_ctrl_a);
    assign {alu_result_b, alu_overflow_b, alu_cout_b, alu_zero_b} =
        alu_model(alu_src1_b, alu_src2_b, alu_ctrl_b);

    alu_cmd_driver #(.Settle(1), .FifoDepth(4)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a),
        .cmd_src1_i(cmd_src1), .cmd_src2_i(cmd_src2), .cmd_ctrl_i(cmd_ctrl), .cmd_tag_i(cmd_tag),
        .alu_rst_no(alu_rst_n_a), .alu_src1_o(alu_src1_a), .alu_src2_o(alu_src2_a),
        .alu_ctrl_o(alu_ctrl_a), .alu_result_i(alu_result_a), .alu_zero_i(alu_zero_a),
        .alu_cout_i(alu_cout_a), .alu_overflow_i(alu_overflow_a),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a), .rsp_result_o(rsp_result_a),
        .rsp_flags_o(rsp_flags_a), .rsp_err_o(rsp_err_a), .rsp_tag_o(rsp_tag_a),
        .busy_o(busy_a), .op_count_o(op_count_a)
    );

    alu_cmd_driver #(.Settle(3), .FifoDepth(4)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b),
        .cmd_src1_i(cmd_src1), .cmd_src2_i(cmd_src2), .cmd_ctrl_i(cmd_ctrl), .cmd_tag_i(cmd_tag),
        .alu_rst_no(alu_rst_n_b), .alu_src1_o(alu_src1_b), .alu_src2_o(alu_src2_b),
        .alu_ctrl_o(alu_ctrl_b), .alu_result_i(alu_result_b), .alu_zero_i(alu_zero_b),
        .alu_cout_i(alu_cout_b), .alu_overflow_i(alu_overflow_b),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_result_o(rsp_result_b),
        .rsp_flags_o(rsp_flags_b), .rsp_err_o(rsp_err_b), .rsp_tag_o(rsp_tag_b),
        .busy_o(busy_b), .op_count_o(op_count_b)
    );

    function automatic rsp_t mk(input logic [31:0] res, input logic [2:0] flags,
                                input logic err, input logic [3:0] tag);
        rsp_t r;
        r.res   = res;
        r.flags = flags;
        r.err   = err;
        r.tag   = tag;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic cmp_rsp(input string name, input rsp_t got, input rsp_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got res=%h flags=%b err=%b tag=%h, expected res=%h flags=%b err=%b tag=%h",
                     name, got.res, got.flags, got.err, got.tag,
                     want.res, want.flags, want.err, want.tag);
        end
    endtask

    // ------------------------------------------------------------ monitors
    rsp_t cur_a, prev_a, cur_b, prev_b;
    bit   stall_a = 0, stall_b = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n && rsp_valid_a) begin
            cur_a = mk(rsp_result_a, rsp_flags_a, rsp_err_a, rsp_tag_a);
            if (stall_a) cmp_rsp("a_stall_stable", cur_a, prev_a);
            if (rsp_ready_a) begin
                if (exp_a.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_unexpected_rsp: got tag %h, expected no response", rsp_tag_a);
                end else begin
                    cmp_rsp("a_rsp", cur_a, exp_a.pop_front());
                end
                stall_a = 0;
            end else begin
                stall_a = 1;
            end
            prev_a = cur_a;
        end else begin
            stall_a = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && rsp_valid_b) begin
            cur_b = mk(rsp_result_b, rsp_flags_b, rsp_err_b, rsp_tag_b);
            if (stall_b) cmp_rsp("b_stall_stable", cur_b, prev_b);
            if (rsp_ready_b) begin
                if (exp_b.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL b_unexpected_rsp: got tag %h, expected no response", rsp_tag_b);
                end else begin
                    cmp_rsp("b_rsp", cur_b, exp_b.pop_front());
                end
                stall_b = 0;
            end else begin
                stall_b = 1;
            end
            prev_b = cur_b;
        end else begin
            stall_b = 0;
        end
    end

    // ------------------------------------------------------------ stimulus
    // Returns #1 after the accepting edge.
    task automatic send(input bit to_b, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [3:0] t,
                        input bit expect_rsp, input rsp_t exp);
        bit got;
        got      = 0;
        cmd_src1 = a;
        cmd_src2 = b;
        cmd_ctrl = c;
        cmd_tag  = t;
        if (to_b) cmd_valid_b = 1'b1;
        else      cmd_valid_a = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (to_b ? cmd_ready_b : cmd_ready_a) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: tag %h never accepted, expected acceptance", t);
        end else if (expect_rsp) begin
            if (to_b) exp_b.push_back(exp);
            else      exp_a.push_back(exp);
        end
        @(posedge clk);
        #1;
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit which_b);
        bit idle;
        idle = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!(which_b ? busy_b : busy_a)) begin
                idle = 1;
                break;
            end
        end
        if (!idle) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy still 1, expected 0");
        end
    endtask

    task automatic chk_reset(input bit b);
        chk("rst_cmd_ready",  b ? cmd_ready_b  : cmd_ready_a,  0);
        chk("rst_rsp_valid",  b ? rsp_valid_b  : rsp_valid_a,  0);
        chk("rst_rsp_result", b ? rsp_result_b : rsp_result_a, 0);
        chk("rst_rsp_flags",  b ? rsp_flags_b  : rsp_flags_a,  0);
        chk("rst_rsp_err",    b ? rsp_err_b    : rsp_err_a,    0);
        chk("rst_rsp_tag",    b ? rsp_tag_b    : rsp_tag_a,    0);
        chk("rst_alu_src1",   b ? alu_src1_b   : alu_src1_a,   0);
        chk("rst_alu_src2",   b ? alu_src2_b   : alu_src2_a,   0);
        chk("rst_alu_ctrl",   b ? alu_ctrl_b   : alu_ctrl_a,   0);
        chk("rst_alu_rst_n",  b ? alu_rst_n_b  : alu_rst_n_a,  0);
        chk("rst_busy",       b ? busy_b       : busy_a,       0);
        chk("rst_op_count",   b ? op_count_b   : op_count_a,   0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", cmd_ready_a, 1);
        chk("post_rst_alu_rst_n", alu_rst_n_a, 1);

        // ADD overflow, response exactly 2 edges after accept
        send(0, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 4'd3, 1, mk(32'h8000_0000, 3'b100, 0, 4'd3));
        chk("add_busy", busy_a, 1);
        @(posedge clk);
        #1;
        chk("add_valid_t1", rsp_valid_a, 0);
        chk("add_alu_src1", alu_src1_a, 32'h7FFF_FFFF);
        chk("add_alu_ctrl", alu_ctrl_a, 4'b0010);
        @(posedge clk);
        #1;
        chk("add_valid_t2", rsp_valid_a, 1);
        wait_idle(0);

        // SUB equal operands
        send(0, 32'd5, 32'd5, 4'b0110, 4'd4, 1, mk(32'h0, 3'b011, 0, 4'd4));
        wait_idle(0);

        // Illegal code: response after 1 edge, ALU lines untouched
        send(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, 4'd9, 1, mk(32'h0, 3'b000, 1, 4'd9));
        @(posedge clk);
        #1;
        chk("ill_valid_t1", rsp_valid_a, 1);
        chk("ill_alu_src1", alu_src1_a, 32'd5);
        chk("ill_alu_src2", alu_src2_a, 32'd5);
        chk("ill_alu_ctrl", alu_ctrl_a, 4'b0110);
        wait_idle(0);

        // Backpressure: 5 commands fill FSM + 4-entry FIFO
        rsp_ready_a = 1'b0;
        send(0, 32'h0F0F_0000, 32'h0000_00F0, 4'b0001, 4'd1, 1, mk(32'h0F0F_00F0, 3'b000, 0, 4'd1));
        send(0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 4'd2, 1, mk(32'h0, 3'b011, 0, 4'd2));
        send(0, 32'h0, 32'h0, 4'b1100, 4'd4, 1, mk(32'hFFFF_FFFF, 3'b000, 0, 4'd4));
        send(0, 32'h1, 32'h2, 4'b0011, 4'd5, 1, mk(32'h0, 3'b000, 1, 4'd5));
        send(0, 32'hFFFF_0000, 32'h0000_FFFF, 4'b0000, 4'd6, 1, mk(32'h0, 3'b001, 0, 4'd6));
        chk("full_cmd_ready", cmd_ready_a, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid", rsp_valid_a, 1);
        chk("stall_tag", rsp_tag_a, 4'd1);
        chk("stall_op_count", op_count_a, 16'd3);
        rsp_ready_a = 1'b1;
        wait_idle(0);
        // 3 earlier responses + 5 from this burst
        chk("burst_op_count", op_count_a, 16'd8);
        chk("a_queue_drained", exp_a.size(), 0);

        // Settle=3 AND: sampled 4 edges after accept, ALU inputs held throughout
        send(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 4'd7, 1, mk(32'hF000_F000, 3'b000, 0, 4'd7));
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk("s3_valid_early", rsp_valid_b, 0);
            chk("s3_alu_src1", alu_src1_b, 32'hF0F0_F0F0);
            chk("s3_alu_src2", alu_src2_b, 32'hFF00_FF00);
            chk("s3_alu_ctrl", alu_ctrl_b, 4'b0000);
        end
        @(posedge clk);
        #1;
        chk("s3_valid_t4", rsp_valid_b, 1);
        chk("s3_alu_src1_t4", alu_src1_b, 32'hF0F0_F0F0);
        wait_idle(1);

        // Reset during SETTLE with two commands queued: no responses may follow
        send(1, 32'd1, 32'd1, 4'b0010, 4'd1, 0, mk(0, 0, 0, 0));
        send(1, 32'd2, 32'd2, 4'b0010, 4'd2, 0, mk(0, 0, 0, 0));
        send(1, 32'd3, 32'd3, 4'b0010, 4'd3, 0, mk(0, 0, 0, 0));
        chk("mid_busy", busy_b, 1);
        chk("mid_valid", rsp_valid_b, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset(1);
        chk_reset(0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_abort_busy", busy_b, 0);
        chk("post_abort_op_count", op_count_b, 0);
        chk("post_abort_valid", rsp_valid_b, 0);
        chk("b_queue_drained", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
